// File: rtl/memory_to_stream_lanes.sv
// memory_to_stream_lanes: captures a MEMORY_DEPTH-element vector in one
// handshake and replays it downstream as MEMORY_DEPTH/LANES beats of LANES
// elements each, honouring backpressure and flagging the last beat of an
// end-of-work vector on eow_o.
// Optional feature macro: M2S_LANES_DOUBLE_BUFFER_EN adds a shadow buffer so
// the next vector can be accepted while the current one streams out, removing
// the idle cycle between vectors.
module memory_to_stream_lanes #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 20,
  parameter int LANES        = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        rtr_o,
  input  logic                        rts_i,
  input  logic                        eow_i,
  input  logic [DATA_WIDTH-1:0]       data_i [MEMORY_DEPTH-1:0],
  input  logic                        rtr_i,
  output logic                        rts_o,
  output logic                        eow_o,
  output logic [LANES*DATA_WIDTH-1:0] data_o
);

  localparam int BEATS = MEMORY_DEPTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = MEMORY_DEPTH * DATA_WIDTH;
  localparam int BW    = LANES * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_B = CW'(BEATS - 1);

  generate
    if (MEMORY_DEPTH % LANES != 0) begin : g_lanes_chk
      $error("memory_to_stream_lanes: MEMORY_DEPTH must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   act_q, act_d;
  logic            act_eow_q, act_eow_d;
  logic [CW-1:0]   b_q, b_d;
  logic [VW-1:0]   data_flat;
  logic [VW-1:0]   act_shifted;
  logic            capture;
  logic            xfer;
  logic            last_beat;

`ifdef M2S_LANES_DOUBLE_BUFFER_EN
  logic [VW-1:0]   sh_q, sh_d;
  logic            sh_eow_q, sh_eow_d;
  logic            sh_vld_q, sh_vld_d;

  // Accept whenever the shadow slot is free, including while streaming.
  assign rtr_o = ~sh_vld_q & ~rst;
`else
  // Accept only between vectors.
  assign rtr_o = (state_q == IDLE) & ~rst;
`endif

  assign capture   = rts_i & rtr_o;
  assign rts_o     = (state_q == SEND);
  assign xfer      = rts_o & rtr_i;
  assign last_beat = (b_q == LAST_B);
  assign eow_o     = rts_o & act_eow_q & last_beat;

  // Flatten the element array so element 0 lands in the LSBs.
  always_comb begin
    data_flat = '0;
    for (int i = 0; i < MEMORY_DEPTH; i++) begin
      data_flat[i*DATA_WIDTH +: DATA_WIDTH] = data_i[i];
    end
  end

  // Select the current beat; outputs are zero whenever no beat is offered.
  always_comb begin
    act_shifted = act_q >> (int'(b_q) * BW);
    data_o      = rts_o ? act_shifted[BW-1:0] : '0;
  end

  // Next-state logic: capture, beat advance and vector hand-over.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    act_eow_d = act_eow_q;
    b_d       = b_q;
`ifdef M2S_LANES_DOUBLE_BUFFER_EN
    sh_d      = sh_q;
    sh_eow_d  = sh_eow_q;
    sh_vld_d  = sh_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d   = SEND;
          act_d     = data_flat;
          act_eow_d = eow_i;
          b_d       = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_beat) begin
            b_d = '0;
`ifdef M2S_LANES_DOUBLE_BUFFER_EN
            if (sh_vld_q) begin
              act_d     = sh_q;
              act_eow_d = sh_eow_q;
              sh_vld_d  = 1'b0;
            end else if (capture) begin
              act_d     = data_flat;
              act_eow_d = eow_i;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            b_d = b_q + CW'(1);
          end
        end
`ifdef M2S_LANES_DOUBLE_BUFFER_EN
        // A capture that is not consumed directly by the active buffer parks
        // in the shadow until the current vector finishes.
        if (capture && !(xfer && last_beat)) begin
          sh_d     = data_flat;
          sh_eow_d = eow_i;
          sh_vld_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset discards any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      act_q     <= '0;
      act_eow_q <= 1'b0;
      b_q       <= '0;
`ifdef M2S_LANES_DOUBLE_BUFFER_EN
      sh_q      <= '0;
      sh_eow_q  <= 1'b0;
      sh_vld_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      act_eow_q <= act_eow_d;
      b_q       <= b_d;
`ifdef M2S_LANES_DOUBLE_BUFFER_EN
      sh_q      <= sh_d;
      sh_eow_q  <= sh_eow_d;
      sh_vld_q  <= sh_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_to_stream_lanes.sv
// Directed bench for memory_to_stream_lanes: a 20-element / 4-lane instance
// and a 1-element / 1-lane instance share clock and reset.
module tb_memory_to_stream_lanes;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_rtr_o, a_rts_i, a_eow_i, a_rtr_i, a_rts_o, a_eow_o;
  logic [15:0] a_data [19:0];
  logic [63:0] a_data_o;

  logic        s_rtr_o, s_rts_i, s_eow_i, s_rtr_i, s_rts_o, s_eow_o;
  logic [15:0] s_data [0:0];
  logic [15:0] s_data_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_to_stream_lanes #(.DATA_WIDTH(16), .MEMORY_DEPTH(20), .LANES(4)) u_dut_a (
    .clk(clk), .rst(rst), .rtr_o(a_rtr_o), .rts_i(a_rts_i), .eow_i(a_eow_i),
    .data_i(a_data), .rtr_i(a_rtr_i), .rts_o(a_rts_o), .eow_o(a_eow_o), .data_o(a_data_o)
  );

  memory_to_stream_lanes #(.DATA_WIDTH(16), .MEMORY_DEPTH(1), .LANES(1)) u_dut_s (
    .clk(clk), .rst(rst), .rtr_o(s_rtr_o), .rts_i(s_rts_i), .eow_i(s_eow_i),
    .data_i(s_data), .rtr_i(s_rtr_i), .rts_o(s_rts_o), .eow_o(s_eow_o), .data_o(s_data_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Beat b of a vector whose element i holds base+i.
  function automatic logic [63:0] exp_beat(input int base, input int b);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(base + b*4 + k);
    return r;
  endfunction

  task automatic load_a(input int base, input logic eow);
    for (int i = 0; i < 20; i++) a_data[i] = 16'(base + i);
    a_eow_i = eow;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic capture_a(input int base, input logic eow);
    load_a(base, eow);
    a_rts_i = 1'b1;
    chk("a_cap_rdy", a_rtr_o, 1'b1);
    step();
    a_rts_i = 1'b0;
    for (int i = 0; i < 20; i++) a_data[i] = 16'hDEAD;
  endtask

  task automatic run_a(input int base, input logic eow);
    capture_a(base, eow);
    a_rtr_i = 1'b1;
    for (int b = 0; b < 5; b++) begin
      chk("run_rts", a_rts_o, 1'b1);
      chk("run_data", a_data_o, exp_beat(base, b));
      chk("run_eow", a_eow_o, eow && (b == 4));
      step();
    end
    chk("run_end_rts", a_rts_o, 1'b0);
    chk("run_end_rtr", a_rtr_o, 1'b1);
  endtask

  task automatic single_s(input logic [15:0] val, input logic eow);
    s_data[0] = val;
    s_eow_i   = eow;
    s_rts_i   = 1'b1;
    chk("s_cap_rdy", s_rtr_o, 1'b1);
    step();
    s_rts_i   = 1'b0;
    s_data[0] = 16'hFFFF;
    s_rtr_i   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("s_rts", s_rts_o, 1'b1);
      chk("s_data", s_data_o, val);
      chk("s_eow", s_eow_o, eow);
      if (c == 1) s_rtr_i = 1'b1;
      step();
    end
    chk("s_end_rts", s_rts_o, 1'b0);
    chk("s_end_eow", s_eow_o, 1'b0);
    chk("s_end_rtr", s_rtr_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    int nxt, c;
    logic x;

    rst = 1'b1;
    a_rts_i = 1'b0; a_eow_i = 1'b0; a_rtr_i = 1'b0;
    s_rts_i = 1'b0; s_eow_i = 1'b0; s_rtr_i = 1'b0;
    load_a(0, 1'b0);
    s_data[0] = '0;
    repeat (3) step();

    // Reset values.
    chk("rst_rts", a_rts_o, 1'b0);
    chk("rst_eow", a_eow_o, 1'b0);
    chk("rst_data", a_data_o, 64'h0);
    chk("rst_rtr", a_rtr_o, 1'b0);
    chk("rst_s_rtr", s_rtr_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_rtr", a_rtr_o, 1'b1);
    chk("post_rst_s_rtr", s_rtr_o, 1'b1);

    // Elements 0..19, eow set, no backpressure.
    capture_a(0, 1'b1);
    a_rtr_i = 1'b1;
    chk("t1_beat0", a_data_o, 64'h0003_0002_0001_0000);
    chk("t1_eow0", a_eow_o, 1'b0);
    repeat (4) step();
    chk("t1_beat4", a_data_o, 64'h0013_0012_0011_0010);
    chk("t1_eow4", a_eow_o, 1'b1);
    step();
    chk("t1_end_rts", a_rts_o, 1'b0);
    chk("t1_end_rtr", a_rtr_o, 1'b1);

    // Backpressure pattern 1,0,0,1 repeating.
    capture_a(0, 1'b1);
    pat = 4'b1001;
    nxt = 0;
    c = 0;
    while (nxt < 5 && c < 40) begin
      a_rtr_i = pat[c % 4];
      chk("stall_rts", a_rts_o, 1'b1);
      chk("stall_data", a_data_o, exp_beat(0, nxt));
      chk("stall_eow", a_eow_o, nxt == 4);
      x = a_rtr_i;
      step();
      if (x) nxt++;
      c++;
    end
    chk("stall_xfers", nxt, 5);
    chk("stall_end_rts", a_rts_o, 1'b0);

    // eow_i=0 vector, then eow_i=1 vector.
    run_a(100, 1'b0);
    run_a(200, 1'b1);

    // Reset on beat 2 of 5.
    capture_a(16'h50, 1'b1);
    a_rtr_i = 1'b1;
    step();
    step();
    chk("mid_beat2", a_data_o, exp_beat(16'h50, 2));
    rst = 1'b1;
    step();
    chk("mid_rst_rts", a_rts_o, 1'b0);
    chk("mid_rst_eow", a_eow_o, 1'b0);
    chk("mid_rst_data", a_data_o, 64'h0);
    chk("mid_rst_rtr", a_rtr_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_post_rtr", a_rtr_o, 1'b1);
    run_a(16'h70, 1'b1);

    // Single-element, single-lane instance.
    single_s(16'hABCD, 1'b1);
    single_s(16'h1234, 1'b0);
    single_s(16'h5A5A, 1'b1);

`ifdef M2S_LANES_DOUBLE_BUFFER_EN
    begin
      int bases [3];
      int caps, ob, occ;
      logic started, cap;
      bases = '{16'h400, 16'h500, 16'h600};
      caps = 0; ob = 0; started = 1'b0;
      a_rtr_i = 1'b1;
      load_a(bases[0], 1'b1);
      a_rts_i = 1'b1;
      for (int cy = 0; cy < 60 && ob < 15; cy++) begin
        occ = caps - ob / 5;
        chk("db_rtr", a_rtr_o, occ < 2);
        if (started || a_rts_o) begin
          started = 1'b1;
          chk("db_rts", a_rts_o, 1'b1);
          chk("db_data", a_data_o, exp_beat(bases[ob/5], ob % 5));
          chk("db_eow", a_eow_o, (ob % 5) == 4);
        end
        cap = a_rts_i & a_rtr_o;
        x = a_rts_o;
        step();
        if (cap) begin
          caps++;
          if (caps < 3) load_a(bases[caps], 1'b1);
          else a_rts_i = 1'b0;
        end
        if (x) ob++;
      end
      chk("db_beats", ob, 15);
      chk("db_end_rts", a_rts_o, 1'b0);
      chk("db_end_rtr", a_rtr_o, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
